// File: rtl/fp_exception_monitor.sv
// Consumer of the FP add/sub exception-flag stream: sticky status, saturating per-flag
// counters, first-offender capture, maskable irq and an edge-qualified req/ack clear.
module fp_exception_monitor #(
  parameter int DWIDTH    = 16,
  parameter int CNT_WIDTH = 8,
  parameter int IDX_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 flags_valid,
  input  logic [4:0]           flags,
  input  logic [DWIDTH-1:0]    result,
  input  logic [4:0]           irq_mask,
  input  logic                 clr_req,
  output logic                 clr_ack,
  output logic [4:0]           sticky,
  input  logic [2:0]           cnt_sel,
  output logic [CNT_WIDTH-1:0] cnt_out,
  output logic [DWIDTH-1:0]    first_result,
  output logic [IDX_WIDTH-1:0] first_idx,
  output logic                 first_vld,
  output logic                 irq,
  output logic [IDX_WIDTH-1:0] beat_idx
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MON     = 2'd1,
    LATCHED = 2'd2,
    CLEAR   = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e                 state_q;
  logic                   clr_req_q;
  logic                   clr_ack_q;
  logic [4:0]             sticky_q;
  logic [CNT_WIDTH-1:0]   cnt_q [5];
  logic [DWIDTH-1:0]      first_result_q;
  logic [IDX_WIDTH-1:0]   first_idx_q;
  logic                   first_vld_q;
  logic                   irq_q;
  logic [IDX_WIDTH-1:0]   beat_idx_q;

  logic accept_s;
  logic clr_start_s;
  logic capture_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Beat acceptance, clear start (rising edge of clr_req only) and first-offender capture.
  always_comb begin
    accept_s    = flags_valid & enable & ((state_q == MON) | (state_q == LATCHED));
    clr_start_s = clr_req & ~clr_req_q & (state_q != CLEAR);
    capture_s   = accept_s & (state_q == MON) & (|flags[4:1]);
  end

  // Counter readback mux.
  always_comb begin
    cnt_out = {CNT_WIDTH{1'b0}};
    case (cnt_sel)
      3'd0:    cnt_out = cnt_q[0];
      3'd1:    cnt_out = cnt_q[1];
      3'd2:    cnt_out = cnt_q[2];
      3'd3:    cnt_out = cnt_q[3];
      3'd4:    cnt_out = cnt_q[4];
      default: cnt_out = {CNT_WIDTH{1'b0}};
    endcase
  end

  // Control FSM and all status state; the clear is applied on the edge that leaves CLEAR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      clr_req_q      <= 1'b0;
      clr_ack_q      <= 1'b0;
      sticky_q       <= 5'd0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= {CNT_WIDTH{1'b0}};
      first_result_q <= {DWIDTH{1'b0}};
      first_idx_q    <= {IDX_WIDTH{1'b0}};
      first_vld_q    <= 1'b0;
      irq_q          <= 1'b0;
      beat_idx_q     <= {IDX_WIDTH{1'b0}};
    end else begin
      clr_req_q <= clr_req;
      clr_ack_q <= 1'b0;
      if (state_q == CLEAR) begin
        sticky_q       <= 5'd0;
        for (int i = 0; i < 5; i++) cnt_q[i] <= {CNT_WIDTH{1'b0}};
        first_result_q <= {DWIDTH{1'b0}};
        first_idx_q    <= {IDX_WIDTH{1'b0}};
        first_vld_q    <= 1'b0;
        irq_q          <= 1'b0;
        beat_idx_q     <= {IDX_WIDTH{1'b0}};
        state_q        <= enable ? MON : IDLE;
      end else begin
        irq_q <= |(sticky_q & irq_mask);
        if (accept_s) begin
          sticky_q   <= sticky_q | flags;
          beat_idx_q <= beat_idx_q + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
          for (int i = 0; i < 5; i++) begin
            if (flags[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
          end
        end
        if (capture_s) begin
          first_result_q <= result;
          first_idx_q    <= beat_idx_q;
          first_vld_q    <= 1'b1;
        end
        if (clr_start_s) begin
          state_q   <= CLEAR;
          clr_ack_q <= 1'b1;
        end else begin
          case (state_q)
            IDLE:    state_q <= enable ? MON : IDLE;
            MON:     state_q <= !enable ? IDLE : (capture_s ? LATCHED : MON);
            LATCHED: state_q <= enable ? LATCHED : IDLE;
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign clr_ack      = clr_ack_q;
  assign sticky       = sticky_q;
  assign first_result = first_result_q;
  assign first_idx    = first_idx_q;
  assign first_vld    = first_vld_q;
  assign irq          = irq_q;
  assign beat_idx     = beat_idx_q;

endmodule
